// File: rtl/i2c_arbiter_if.sv
// Client/master-side signal bundle for the shared i2c_master arbiter.
// master: the arbiter side; slave: clients plus the i2c_master instance.
interface i2c_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        REQ;
    logic [NREQ-1:0][23:0]  RQD;
    logic                   FLT_CLR;
    logic [NREQ-1:0]        GNT;
    logic [NREQ-1:0]        DONE;
    logic [7:0]             RDATA;
    logic [3:0]             RSTAT;
    logic                   FAULT;
    logic                   M_ACT;
    logic                   M_CMD;
    logic [7:0]             M_BE;
    logic [63:0]            M_DI;
    logic [7:0]             M_DO;
    logic [3:0]             M_SO;

    modport master (
        input  REQ, RQD, FLT_CLR, M_DO, M_SO,
        output GNT, DONE, RDATA, RSTAT, FAULT, M_ACT, M_CMD, M_BE, M_DI
    );

    modport slave (
        output REQ, RQD, FLT_CLR, M_DO, M_SO,
        input  GNT, DONE, RDATA, RSTAT, FAULT, M_ACT, M_CMD, M_BE, M_DI
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NREQ clients.
// Loads byte1, byte2, then the address byte (which starts the master),
// waits for completion with a timeout and returns data/status.
module i2c_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [23:0] TMO_CYC = 24'd1000000
) (
    input  logic           CLK,
    input  logic           RST,
    i2c_arbiter_if.master  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE, LD1, LD2, LD0, GUARD, WAIT, DNE, FDONE
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] win_oh;
    logic [23:0]     rqd_q;
    logic [23:0]     cnt;
    logic            fault_q;
    logic            so_done;
    logic            tmo_hit;
    logic            fault_set;

    assign so_done   = bus.M_SO[3];
    assign tmo_hit   = (cnt == TMO_CYC - 24'd1);
    // Completion wins over timeout when both land in the same WAIT cycle.
    assign fault_set = (state == WAIT) && !so_done && tmo_hit;
    assign win_oh    = NREQ'(1) << win;
    assign bus.FAULT = fault_q;
    assign bus.M_CMD = 1'b0;

    // Round-robin pick: first set REQ searching upward from ptr+1 with wrap.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && bus.REQ[idx]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: fixed load order, BE[0] write last because it starts the master.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = fault_q ? FDONE : LD1;
            LD1:     state_nx = LD2;
            LD2:     state_nx = LD0;
            LD0:     state_nx = GUARD;
            GUARD:   state_nx = WAIT;
            WAIT:    if (so_done || tmo_hit) state_nx = DNE;
            DNE:     state_nx = IDLE;
            FDONE:   state_nx = DNE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs, grant/pointer, latched request word and WAIT counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.GNT   <= '0;
            bus.DONE  <= '0;
            bus.RDATA <= 8'h00;
            bus.RSTAT <= 4'h0;
            bus.M_ACT <= 1'b0;
            bus.M_BE  <= 8'hFF;
            bus.M_DI  <= 64'h0;
            ptr       <= PW'(NREQ - 1);
            rqd_q     <= 24'h0;
            cnt       <= 24'h0;
        end else begin
            bus.DONE  <= '0;
            bus.M_ACT <= 1'b0;
            bus.M_BE  <= 8'hFF;
            bus.M_DI  <= 64'h0;
            case (state)
                IDLE: if (found) begin
                    bus.GNT <= win_oh;
                    ptr     <= win;
                    rqd_q   <= bus.RQD[win];
                end
                LD1: begin
                    bus.M_ACT       <= 1'b1;
                    bus.M_BE        <= 8'hFD;
                    bus.M_DI[15:8]  <= rqd_q[15:8];
                end
                LD2: begin
                    bus.M_ACT       <= 1'b1;
                    bus.M_BE        <= 8'hFB;
                    bus.M_DI[23:16] <= rqd_q[23:16];
                end
                LD0: begin
                    bus.M_ACT       <= 1'b1;
                    bus.M_BE        <= 8'hFE;
                    bus.M_DI[7:0]   <= rqd_q[7:0];
                end
                // SO is stale here: the master clears it on the BE[0] write.
                GUARD: cnt <= 24'h0;
                WAIT: begin
                    cnt <= cnt + 24'd1;
                    if (so_done || tmo_hit) begin
                        bus.DONE  <= bus.GNT;
                        bus.RDATA <= bus.M_DO;
                        bus.RSTAT <= {!so_done, bus.M_SO[2:0]};
                    end
                end
                FDONE: begin
                    bus.DONE  <= bus.GNT;
                    bus.RDATA <= 8'h00;
                    bus.RSTAT <= 4'b1000;
                end
                DNE: bus.GNT <= '0;
                default: ;
            endcase
        end
    end

    // Sticky fault: set on timeout, FLT_CLR clears, set wins a tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            fault_q <= 1'b0;
        else if (fault_set) fault_q <= 1'b1;
        else if (bus.FLT_CLR) fault_q <= 1'b0;
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: vector table plus directed sequences.
module tb_i2c_arbiter;
    localparam int NREQ = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0][23:0] rqd = '0;
    logic                  flt_clr = 1'b0;
    logic [7:0]            m_do = 8'h00;
    logic [3:0]            m_so = 4'h0;

    always #5 CLK = ~CLK;

    i2c_arbiter_if #(.NREQ(NREQ)) bus ();
    assign bus.REQ     = req;
    assign bus.RQD     = rqd;
    assign bus.FLT_CLR = flt_clr;
    assign bus.M_DO    = m_do;
    assign bus.M_SO    = m_so;

    i2c_arbiter #(.NREQ(NREQ), .TMO_CYC(24'd16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.master)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Master model: after the BE[0] strobe, SO clears; mdl_lat negedges later
    // it reports mdl_so / mdl_do. mdl_lat = 0 means never complete.
    int mdl_lat = 0;
    logic [3:0] mdl_so = 4'h0;
    logic [7:0] mdl_do = 8'h00;
    int tick = 0;
    bit armed = 0;
    always @(negedge CLK) begin
        if (bus.M_ACT && bus.M_BE == 8'hFE) begin
            m_so <= 4'h0; tick = 0; armed = 1;
        end else if (armed) begin
            tick++;
            if (tick == mdl_lat) begin
                m_so <= mdl_so; m_do <= mdl_do; armed = 0;
            end
        end
    end

    int multi_gnt = 0;
    always @(negedge CLK) if ($countones(bus.GNT) > 1) multi_gnt++;

    // Results of the last run_txn.
    int r_gnt, r_gcyc, r_nact, r_ndone, r_lat, r_to;
    logic [7:0]  r_be [3];
    logic [63:0] r_di [3];
    int          r_actc [3];
    logic [NREQ-1:0] r_dvec;
    logic [7:0] r_rdata;
    logic [3:0] r_rstat;

    task automatic run_txn(input int idx, input logic [23:0] w, input int lat,
                           input logic [3:0] so, input logic [7:0] dval);
        int cyc, ts;
        mdl_lat = lat; mdl_so = so; mdl_do = dval;
        rqd[idx] = w; req[idx] = 1'b1;
        r_gnt = -1; r_gcyc = 0; r_nact = 0; r_ndone = 0; r_to = 1; r_lat = 0;
        r_dvec = '0; r_rdata = 8'h00; r_rstat = 4'h0;
        for (int k = 0; k < 3; k++) begin r_be[k] = 8'h00; r_di[k] = 64'h0; r_actc[k] = 0; end
        cyc = 0; ts = 0;
        while (cyc < 200) begin
            @(negedge CLK); cyc++;
            if (bus.GNT != '0 && r_gnt < 0) begin r_gnt = oh_idx(bus.GNT); r_gcyc = cyc; end
            if (bus.M_ACT) begin
                if (r_nact < 3) begin
                    r_be[r_nact] = bus.M_BE; r_di[r_nact] = bus.M_DI; r_actc[r_nact] = cyc;
                end
                r_nact++;
                if (bus.M_BE == 8'hFE) ts = cyc;
            end
            if (bus.DONE != '0) begin
                r_ndone++; r_dvec = bus.DONE; r_rdata = bus.RDATA; r_rstat = bus.RSTAT;
                r_lat = cyc - ts; req[idx] = 1'b0; r_to = 0;
                break;
            end
        end
        if (r_to != 0) req[idx] = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.DONE != '0) r_ndone++;
            if (bus.M_ACT) r_nact++;
        end
        chk("txn_no_timeout_of_bench", 64'(r_to), 64'd0);
    endtask

    typedef struct {
        int          idx;
        logic [23:0] w;
        int          lat;
        logic [3:0]  so;
        logic [7:0]  mdo;
        logic [7:0]  e_rdata;
        logic [3:0]  e_rstat;
        int          e_lat;
    } vec_t;

    vec_t vt [5];
    int order [5];

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_gnt",  64'(bus.GNT),  64'h0);
        chk("rst_done", 64'(bus.DONE), 64'h0);
        chk("rst_rdata_rstat", {52'h0, bus.RDATA, bus.RSTAT}, 64'h0);
        chk("rst_mact_cmd_fault", {61'h0, bus.M_ACT, bus.M_CMD, bus.FAULT}, 64'h0);
        chk("rst_mbe",  64'(bus.M_BE), 64'hFF);
        chk("rst_mdi",  bus.M_DI, 64'h0);
        RST = 1'b0;
        @(negedge CLK);

        // idx, word, model latency, SO, DO, expected RDATA, RSTAT, strobe->DONE
        vt[0] = '{1, 24'h5AA550, 5,  4'b1000, 8'h00, 8'h00, 4'b0000, 6};
        vt[1] = '{0, 24'h7766A1, 3,  4'b1000, 8'h3C, 8'h3C, 4'b0000, 4};
        vt[2] = '{2, 24'h123456, 4,  4'b1011, 8'h99, 8'h99, 4'b0011, 5};
        vt[3] = '{3, 24'hC3B2A1, 16, 4'b1101, 8'h55, 8'h55, 4'b0101, 17};
        vt[4] = '{1, 24'h0F0E0D, 1,  4'b1000, 8'hE7, 8'hE7, 4'b0000, 2};
        for (int v = 0; v < 5; v++) begin
            run_txn(vt[v].idx, vt[v].w, vt[v].lat, vt[v].so, vt[v].mdo);
            chk($sformatf("v%0d_gnt", v), 64'(r_gnt), 64'(vt[v].idx));
            chk($sformatf("v%0d_nact", v), 64'(r_nact), 64'd3);
            chk($sformatf("v%0d_ld1", v), {r_be[0], r_di[0][55:0]}, {8'hFD, 40'h0, vt[v].w[15:8], 8'h00});
            chk($sformatf("v%0d_ld2", v), {r_be[1], r_di[1][55:0]}, {8'hFB, 32'h0, vt[v].w[23:16], 16'h0});
            chk($sformatf("v%0d_ld0", v), {r_be[2], r_di[2][55:0]}, {8'hFE, 48'h0, vt[v].w[7:0]});
            chk($sformatf("v%0d_di_hi", v), {r_di[0][63:56], r_di[1][63:56], r_di[2][63:56]}, 64'h0);
            chk($sformatf("v%0d_ld0_after_gnt", v), 64'(r_actc[2] - r_gcyc), 64'd3);
            chk($sformatf("v%0d_consecutive", v), 64'(r_actc[2] - r_actc[0]), 64'd2);
            chk($sformatf("v%0d_ndone", v), 64'(r_ndone), 64'd1);
            chk($sformatf("v%0d_dvec", v), 64'(r_dvec), 64'(1 << vt[v].idx));
            chk($sformatf("v%0d_rdata", v), 64'(r_rdata), 64'(vt[v].e_rdata));
            chk($sformatf("v%0d_rstat", v), 64'(r_rstat), 64'(vt[v].e_rstat));
            chk($sformatf("v%0d_lat", v), 64'(r_lat), 64'(vt[v].e_lat));
            chk($sformatf("v%0d_fault", v), 64'(bus.FAULT), 64'd0);
        end

        // Timeout: 16 WAIT cycles after the GUARD cycle.
        run_txn(2, 24'h0000C4, 0, 4'h0, 8'h00);
        chk("tmo_lat",   64'(r_lat),   64'd17);
        chk("tmo_rstat", 64'(r_rstat), 64'h8);
        chk("tmo_dvec",  64'(r_dvec),  64'h4);
        chk("tmo_fault", 64'(bus.FAULT), 64'd1);
        // Fault mode: master untouched.
        run_txn(1, 24'h0000A2, 1, 4'h8, 8'h77);
        chk("fdone_nact",  64'(r_nact),  64'd0);
        chk("fdone_rstat", 64'(r_rstat), 64'h8);
        chk("fdone_rdata", 64'(r_rdata), 64'h0);
        chk("fdone_dvec",  64'(r_dvec),  64'h2);
        chk("fdone_ndone", 64'(r_ndone), 64'd1);
        chk("fdone_fault_sticky", 64'(bus.FAULT), 64'd1);
        flt_clr = 1'b1;
        @(negedge CLK);
        flt_clr = 1'b0;
        chk("fltclr_fault", 64'(bus.FAULT), 64'd0);
        run_txn(3, 24'h3322F0, 2, 4'h8, 8'hAB);
        chk("resume_nact",  64'(r_nact),  64'd3);
        chk("resume_rstat", 64'(r_rstat), 64'h0);
        chk("resume_rdata", 64'(r_rdata), 64'hAB);

        // Reset mid-WAIT
        mdl_lat = 0;
        rqd[2] = 24'h000044; req[2] = 1'b1;
        repeat (10) @(negedge CLK);
        RST = 1'b1; req = '0;
        @(negedge CLK);
        chk("mrst_gnt",  64'(bus.GNT),  64'h0);
        chk("mrst_mact", 64'(bus.M_ACT), 64'h0);
        chk("mrst_mbe",  64'(bus.M_BE), 64'hFF);
        RST = 1'b0;
        begin
            int nd;
            nd = 0;
            repeat (20) begin
                @(negedge CLK);
                if (bus.DONE != '0) nd++;
            end
            chk("mrst_no_done", 64'(nd), 64'd0);
        end

        // Round-robin with all requests held; pointer is back at NREQ-1.
        mdl_lat = 2; mdl_so = 4'h8; mdl_do = 8'h11;
        for (int i = 0; i < NREQ; i++) rqd[i] = {8'h10, 8'h20, 8'(8'h30 + i)};
        req = '1;
        begin
            int nd, cyc;
            nd = 0; cyc = 0;
            while (nd < 5 && cyc < 400) begin
                @(negedge CLK); cyc++;
                if (bus.DONE != '0) begin
                    chk($sformatf("rr%0d_done_eq_gnt", nd), 64'(bus.DONE), 64'(bus.GNT));
                    order[nd] = oh_idx(bus.GNT);
                    nd++;
                end
            end
            req = '0;
            chk("rr_count", 64'(nd), 64'd5);
            for (int k = 0; k < nd; k++)
                chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % NREQ));
        end
        repeat (5) @(negedge CLK);
        chk("never_multi_gnt", 64'(multi_gnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
